// File: rtl/pipe_control_seq.sv
// Pipelined control for the 16-bit core: ID decode, registered EX/MEM/WB control bundles,
// multi-cycle mul/div stall sequencing, IF flush windows and a sticky halt.
module pipe_control_seq #(
    parameter int unsigned OPW          = 4,
    parameter int unsigned FW           = 4,
    parameter int unsigned MUL_LAT      = 3,
    parameter int unsigned DIV_LAT      = 8,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FW-1:0]  func,
    input  logic           id_valid,
    input  logic           jorb,
    output logic           j,
    output logic [1:0]     bType,
    output logic           IFFlush,
    output logic           pc_stall,
    output logic [1:0]     ex_useFunc,
    output logic           ex_offsetSel,
    output logic           mem_mWrite,
    output logic           mem_mRead,
    output logic           mem_mByte,
    output logic [1:0]     wb_rWrite,
    output logic           halted
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned BW     = $clog2(MaxLat + 1);
    localparam int unsigned FCW    = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StMulti = 2'd1;
    localparam logic [1:0] StHalt  = 2'd2;

    localparam logic [OPW-1:0] OpAType = OPW'(4'b0000);
    localparam logic [OPW-1:0] OpAndi  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OpOri   = OPW'(4'b0010);
    localparam logic [OPW-1:0] OpBlt   = OPW'(4'b0100);
    localparam logic [OPW-1:0] OpBgt   = OPW'(4'b0101);
    localparam logic [OPW-1:0] OpBeq   = OPW'(4'b0110);
    localparam logic [OPW-1:0] OpLbu   = OPW'(4'b1000);
    localparam logic [OPW-1:0] OpSb    = OPW'(4'b1001);
    localparam logic [OPW-1:0] OpLw    = OPW'(4'b1010);
    localparam logic [OPW-1:0] OpSw    = OPW'(4'b1011);
    localparam logic [OPW-1:0] OpJump  = OPW'(4'b1100);
    localparam logic [OPW-1:0] OpHalt  = OPW'(4'b1111);

    localparam logic [FW-1:0] FuncMul  = FW'(4'b0100);
    localparam logic [FW-1:0] FuncDiv  = FW'(4'b1000);
    localparam logic [FW-1:0] FuncSwap = FW'(4'b1111);

    typedef struct packed {
        logic [1:0] rwrite;
        logic       mbyte;
        logic       mread;
        logic       mwrite;
        logic       offset_sel;
        logic [1:0] use_func;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] rwrite;
        logic       mbyte;
        logic       mread;
        logic       mwrite;
    } mem_ctrl_t;

    localparam ctrl_t CtrlNop = '{
        rwrite: 2'b00, mbyte: 1'b0, mread: 1'b1, mwrite: 1'b1, offset_sel: 1'b0, use_func: 2'b00
    };
    localparam mem_ctrl_t MemNop = '{rwrite: 2'b00, mbyte: 1'b0, mread: 1'b1, mwrite: 1'b1};

    logic [1:0]     state_q, state_d;
    logic [BW-1:0]  busy_q, busy_d;
    logic [FCW-1:0] flush_q, flush_d;
    ctrl_t          ex_q, ex_d;
    mem_ctrl_t      mem_q, mem_d;
    logic [1:0]     wb_q, wb_d;

    ctrl_t          id_ctrl;
    logic           id_j;
    logic [1:0]     id_btype;
    logic           is_halt;
    logic           is_mul;
    logic           is_div;
    logic           multi_start;
    logic           flush_start;

    // ID decode; an invalid slot decodes as a NOP with no jump/branch.
    always_comb begin
        id_ctrl  = CtrlNop;
        id_j     = 1'b0;
        id_btype = 2'b00;
        is_halt  = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        if (id_valid) begin
            case (opcode)
                OpAType: begin
                    case (func)
                        FuncMul: begin
                            id_ctrl.rwrite = 2'b11;
                            is_mul         = 1'b1;
                        end
                        FuncDiv: begin
                            id_ctrl.rwrite = 2'b11;
                            is_div         = 1'b1;
                        end
                        FuncSwap: id_ctrl.rwrite = 2'b10;
                        default:  id_ctrl.rwrite = 2'b01;
                    endcase
                end
                OpAndi: begin
                    id_ctrl.rwrite     = 2'b01;
                    id_ctrl.use_func   = 2'b11;
                    id_ctrl.offset_sel = 1'b1;
                end
                OpOri: begin
                    id_ctrl.rwrite     = 2'b01;
                    id_ctrl.use_func   = 2'b10;
                    id_ctrl.offset_sel = 1'b1;
                end
                OpLbu: begin
                    id_ctrl.rwrite   = 2'b01;
                    id_ctrl.mread    = 1'b0;
                    id_ctrl.mbyte    = 1'b1;
                    id_ctrl.use_func = 2'b01;
                end
                OpLw: begin
                    id_ctrl.rwrite   = 2'b01;
                    id_ctrl.mread    = 1'b0;
                    id_ctrl.use_func = 2'b01;
                end
                OpSb: begin
                    id_ctrl.mwrite   = 1'b0;
                    id_ctrl.mbyte    = 1'b1;
                    id_ctrl.use_func = 2'b01;
                end
                OpSw: begin
                    id_ctrl.mwrite   = 1'b0;
                    id_ctrl.use_func = 2'b01;
                end
                OpBlt:   id_btype = 2'b10;
                OpBgt:   id_btype = 2'b11;
                OpBeq:   id_btype = 2'b01;
                OpJump:  id_j     = 1'b1;
                OpHalt:  is_halt  = 1'b1;
                default: id_ctrl  = CtrlNop;
            endcase
        end
    end

    assign multi_start = (is_mul && (MUL_LAT > 1)) || (is_div && (DIV_LAT > 1));

    // Halt wins over a coincident redirect; ID is frozen outside RUN so nothing starts there.
    assign flush_start = (state_q == StRun) && !is_halt && (id_j || jorb);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        case (state_q)
            StRun: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (multi_start) begin
                    state_d = StMulti;
                    busy_d  = is_div ? BW'(DIV_LAT - 1) : BW'(MUL_LAT - 1);
                end
            end
            StMulti: begin
                busy_d = busy_q - BW'(1);
                if (busy_q == BW'(1)) begin
                    state_d = StRun;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        flush_d = flush_q;
        if (flush_start) begin
            flush_d = FCW'(FLUSH_CYCLES - 1);
        end else if (flush_q != '0) begin
            flush_d = flush_q - FCW'(1);
        end
    end

    // EX holds during MULTI while MEM takes bubbles; in HALT the pipe drains with NOPs.
    always_comb begin
        ex_d  = ex_q;
        mem_d = '{rwrite: ex_q.rwrite, mbyte: ex_q.mbyte, mread: ex_q.mread, mwrite: ex_q.mwrite};
        wb_d  = mem_q.rwrite;
        case (state_q)
            StRun:   ex_d  = id_ctrl;
            StMulti: mem_d = MemNop;
            StHalt:  ex_d  = CtrlNop;
            default: ex_d  = CtrlNop;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            busy_q  <= '0;
            flush_q <= '0;
            ex_q    <= CtrlNop;
            mem_q   <= MemNop;
            wb_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            flush_q <= flush_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign j            = id_j;
    assign bType        = id_btype;
    // The combinational flush term is masked so IFFlush is low for the whole reset window.
    assign IFFlush      = reset && ((state_q == StHalt) || flush_start || (flush_q != '0));
    assign pc_stall     = (state_q == StMulti) || (state_q == StHalt);
    assign halted       = (state_q == StHalt);
    assign ex_useFunc   = ex_q.use_func;
    assign ex_offsetSel = ex_q.offset_sel;
    assign mem_mWrite   = mem_q.mwrite;
    assign mem_mRead    = mem_q.mread;
    assign mem_mByte    = mem_q.mbyte;
    assign wb_rWrite    = wb_q;

endmodule

// File: tb/tb_pipe_control_seq.sv
// Bench for pipe_control_seq: directed vector tables, directed stall/reset sequences and
// a randomized run against a cycle-level reference model.
module tb_pipe_control_seq;

    localparam int unsigned MulLat = 3;
    localparam int unsigned DivLat = 8;
    localparam int unsigned FlushCycles = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] func;
    logic       id_valid;
    logic       jorb;
    logic       j;
    logic [1:0] bType;
    logic       IFFlush;
    logic       pc_stall;
    logic [1:0] ex_useFunc;
    logic       ex_offsetSel;
    logic       mem_mWrite;
    logic       mem_mRead;
    logic       mem_mByte;
    logic [1:0] wb_rWrite;
    logic       halted;

    pipe_control_seq #(
        .OPW          (4),
        .FW           (4),
        .MUL_LAT      (MulLat),
        .DIV_LAT      (DivLat),
        .FLUSH_CYCLES (FlushCycles)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .func         (func),
        .id_valid     (id_valid),
        .jorb         (jorb),
        .j            (j),
        .bType        (bType),
        .IFFlush      (IFFlush),
        .pc_stall     (pc_stall),
        .ex_useFunc   (ex_useFunc),
        .ex_offsetSel (ex_offsetSel),
        .mem_mWrite   (mem_mWrite),
        .mem_mRead    (mem_mRead),
        .mem_mByte    (mem_mByte),
        .wb_rWrite    (wb_rWrite),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // {j, bType, IFFlush, pc_stall, ex_useFunc, ex_offsetSel, mWrite, mRead, mByte, rWrite, halted}
    logic [13:0] dut_out;
    assign dut_out = {j, bType, IFFlush, pc_stall, ex_useFunc, ex_offsetSel,
                      mem_mWrite, mem_mRead, mem_mByte, wb_rWrite, halted};

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  fn;
        logic        v;
        logic        jb;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] fn, input logic v,
                                input logic jb, input logic ej, input logic [1:0] ebt,
                                input logic eiff, input logic est, input logic [1:0] euf,
                                input logic eos, input logic emw, input logic emr,
                                input logic emb, input logic [1:0] erw, input logic eh);
        vec_t r;
        r.op  = op;
        r.fn  = fn;
        r.v   = v;
        r.jb  = jb;
        r.exp = {ej, ebt, eiff, est, euf, eos, emw, emr, emb, erw, eh};
        return r;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] fn, input logic v,
                         input logic jb);
        opcode   = op;
        func     = fn;
        id_valid = v;
        jorb     = jb;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: stage contents held as plain records, stall/flush as remaining-cycle counts.
    typedef struct packed {
        logic [1:0] uf;
        logic       os;
        logic       mw;
        logic       mr;
        logic       mb;
        logic [1:0] rw;
    } bnd_t;

    localparam bnd_t BndNop = '{uf: 2'b00, os: 1'b0, mw: 1'b1, mr: 1'b1, mb: 1'b0, rw: 2'b00};

    bnd_t       m_ex, m_mem;
    logic [1:0] m_wb;
    int         stall_left, flush_left;
    bit         m_halted;

    function automatic void ref_decode(input logic [3:0] op, input logic [3:0] fn, input logic v,
                                       output bnd_t b, output logic dj, output logic [1:0] bt,
                                       output bit hlt, output int lat);
        b = BndNop; dj = 0; bt = 2'b00; hlt = 0; lat = 1;
        if (v) begin
            if (op == 4'h0) begin
                b.rw = 2'b01;
                if (fn == 4'h4) begin b.rw = 2'b11; lat = MulLat; end
                if (fn == 4'h8) begin b.rw = 2'b11; lat = DivLat; end
                if (fn == 4'hF) b.rw = 2'b10;
            end
            if (op == 4'h1) begin b.rw = 2'b01; b.uf = 2'b11; b.os = 1; end
            if (op == 4'h2) begin b.rw = 2'b01; b.uf = 2'b10; b.os = 1; end
            if (op == 4'h8) begin b.rw = 2'b01; b.mr = 0; b.mb = 1; b.uf = 2'b01; end
            if (op == 4'hA) begin b.rw = 2'b01; b.mr = 0; b.uf = 2'b01; end
            if (op == 4'h9) begin b.mw = 0; b.mb = 1; b.uf = 2'b01; end
            if (op == 4'hB) begin b.mw = 0; b.uf = 2'b01; end
            if (op == 4'h4) bt = 2'b10;
            if (op == 4'h5) bt = 2'b11;
            if (op == 4'h6) bt = 2'b01;
            if (op == 4'hC) dj = 1;
            if (op == 4'hF) hlt = 1;
        end
    endfunction

    function automatic void model_reset();
        m_ex = BndNop; m_mem = BndNop; m_wb = 2'b00;
        stall_left = 0; flush_left = 0; m_halted = 0;
    endfunction

    // Returns this cycle's expected outputs and advances the model by one clock.
    function automatic logic [13:0] model_step(input logic [3:0] op, input logic [3:0] fn,
                                               input logic v, input logic jb);
        bnd_t b;
        logic dj;
        logic [1:0] bt;
        bit hlt, running, start;
        int lat;
        logic [13:0] e;
        ref_decode(op, fn, v, b, dj, bt, hlt, lat);
        running = !m_halted && (stall_left == 0);
        start = running && !hlt && (dj || jb);
        e = {dj, bt, m_halted || start || (flush_left > 0), m_halted || (stall_left > 0),
             m_ex.uf, m_ex.os, m_mem.mw, m_mem.mr, m_mem.mb, m_wb, m_halted};
        m_wb = m_mem.rw;
        if (m_halted) begin
            m_mem = m_ex; m_ex = BndNop;
        end else if (stall_left > 0) begin
            m_mem = BndNop; stall_left--;
        end else begin
            m_mem = m_ex; m_ex = b;
            if (hlt) m_halted = 1;
            else if (lat > 1) stall_left = lat - 1;
        end
        if (start) flush_left = FlushCycles - 1;
        else if (flush_left > 0) flush_left--;
        return e;
    endfunction

    vec_t tab[13];
    vec_t mtab[7];

    initial begin
        int stall_cnt, wb_at, halt_cycles;
        logic [3:0] rop, rfn;
        logic rv, rjb;
        logic [13:0] e;

        // lw / andi / ori / jump with flush reload / beq / sb / halt
        tab[0]  = mk(4'hA, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        tab[1]  = mk(4'h1, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b01, 0,  1, 1, 0,  2'b00, 0);
        tab[2]  = mk(4'hA, 4'h0, 0, 0,  0, 2'b00, 0, 0,  2'b11, 1,  1, 0, 0,  2'b00, 0);
        tab[3]  = mk(4'h2, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b01, 0);
        tab[4]  = mk(4'hC, 4'h0, 1, 0,  1, 2'b00, 1, 0,  2'b10, 1,  1, 1, 0,  2'b01, 0);
        tab[5]  = mk(4'h6, 4'h0, 1, 1,  0, 2'b01, 1, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        tab[6]  = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 1, 0,  2'b00, 0,  1, 1, 0,  2'b01, 0);
        tab[7]  = mk(4'h9, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        tab[8]  = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b01, 0,  1, 1, 0,  2'b00, 0);
        tab[9]  = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  0, 1, 1,  2'b00, 0);
        tab[10] = mk(4'hF, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        tab[11] = mk(4'h4, 4'h0, 1, 1,  0, 2'b10, 1, 1,  2'b00, 0,  1, 1, 0,  2'b00, 1);
        tab[12] = mk(4'hC, 4'h0, 1, 0,  1, 2'b00, 1, 1,  2'b00, 0,  1, 1, 0,  2'b00, 1);

        // mul then an add held in ID through the stall
        mtab[0] = mk(4'h0, 4'h4, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        mtab[1] = mk(4'h0, 4'h0, 1, 0,  0, 2'b00, 0, 1,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        mtab[2] = mk(4'h0, 4'h0, 1, 0,  0, 2'b00, 0, 1,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        mtab[3] = mk(4'h0, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        mtab[4] = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b00, 0);
        mtab[5] = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b11, 0);
        mtab[6] = mk(4'h7, 4'h0, 1, 0,  0, 2'b00, 0, 0,  2'b00, 0,  1, 1, 0,  2'b01, 0);

        do_reset();
        #3;
        check("reset_state", dut_out, 14'b0_00_0_0_00_0_1_1_0_00_0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(tab[i].op, tab[i].fn, tab[i].v, tab[i].jb);
            #3;
            check($sformatf("seq_vec%0d", i), dut_out, tab[i].exp);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            #3;
            check($sformatf("halt_sticky%0d", i), {3'b000, dut_out[10:0]},
                  14'b000_1_1_00_0_1_1_0_00_1);
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(mtab[i].op, mtab[i].fn, mtab[i].v, mtab[i].jb);
            #3;
            check($sformatf("mul_vec%0d", i), dut_out, mtab[i].exp);
            @(posedge clk);
            #1;
        end

        // div: count stall cycles and locate the WB pair write, within a bounded window
        do_reset();
        drive(4'h0, 4'h8, 1, 0);
        @(posedge clk);
        #1;
        drive(4'h7, 4'h0, 0, 0);
        stall_cnt = 0;
        wb_at = -1;
        for (int k = 1; k <= 20; k++) begin
            #3;
            if (pc_stall) stall_cnt++;
            if (wb_rWrite == 2'b11 && wb_at < 0) wb_at = k;
            @(posedge clk);
            #1;
        end
        check("div_stall_cycles", 14'(stall_cnt), 14'(DivLat - 1));
        check("div_wb_cycle", 14'(wb_at), 14'(DivLat + 2));

        // asynchronous reset in the middle of a divide, with a redirect pending in ID
        drive(4'h0, 4'h8, 1, 0);
        @(posedge clk);
        #1;
        drive(4'hC, 4'h0, 1, 1);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_stall", {13'd0, pc_stall}, 14'd1);
        reset = 1'b0;
        #1;
        check("async_reset_mid_multi", dut_out, 14'b1_00_0_0_00_0_1_1_0_00_0);
        #1;
        reset = 1'b1;
        drive(4'h7, 4'h0, 0, 0);
        @(posedge clk);
        #1;

        // randomized run against the reference model
        do_reset();
        model_reset();
        halt_cycles = 0;
        for (int c = 0; c < 1500; c++) begin
            rop = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 79) == 0) rop = 4'hF;
            rfn = ($urandom_range(0, 1) == 0) ? 4'($urandom) :
                  (($urandom_range(0, 1) == 0) ? 4'h4 : (($urandom_range(0, 1) == 0) ? 4'h8 : 4'hF));
            rv  = ($urandom_range(0, 9) != 0);
            rjb = ($urandom_range(0, 9) == 0);
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4 || $urandom_range(0, 149) == 0) begin
                halt_cycles = 0;
                drive(rop, rfn, 1'b0, 1'b0);
                reset = 1'b0;
                model_reset();
                #3;
                e = model_step(rop, rfn, 1'b0, 1'b0);
                check($sformatf("rand_reset%0d", c), dut_out, e);
                reset = 1'b1;
            end else begin
                drive(rop, rfn, rv, rjb);
                #3;
                e = model_step(rop, rfn, rv, rjb);
                check($sformatf("rand%0d", c), dut_out, e);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
